fpu_op_dispatch: RTL and testbench

//  Sequencer between the FPU bus interface and the arithmetic units. Captures a request
//  (2-bit opcode + two operands), decodes it, pulses the start of exactly one unit
//  (add/sub, mult, cordic), waits for that unit's ready, registers its result and

---
 rtl/fpu_if_pkg.sv | 14 +
 rtl/fpu_op_watchdog.sv | 16 +
 rtl/fpu_op_dispatch.sv | 87 ++++++++
 tb/tb_fpu_op_dispatch.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_if_pkg.sv
// fpu_if_pkg: opcode constants and dispatch FSM state encoding shared by the FPU interface blocks.
package fpu_if_pkg;
  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_SUB    = 2'b01;
  localparam logic [1:0] OP_MULT   = 2'b10;
  localparam logic [1:0] OP_CORDIC = 2'b11;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;
endpackage

// File: rtl/fpu_op_watchdog.sv
// fpu_op_watchdog: counts cycles while active and flags expiry after TMO_CYC of them.
module fpu_op_watchdog #(
  parameter int TMO_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic expire
);
  localparam int CW = $clog2(TMO_CYC + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || !active) cnt <= '0;
    else cnt <= cnt + CW'(1);
  assign expire = active && cnt == CW'(TMO_CYC - 1);
endmodule

// File: rtl/fpu_op_dispatch.sv
// fpu_op_dispatch: sequences one FPU request at a time to add/sub, mult or cordic; FPU_DISPATCH_TMO_EN adds a WAIT watchdog.
module fpu_op_dispatch
  import fpu_if_pkg::*;
#(
  parameter int W       = 32,
  parameter int TMO_CYC = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         beg_op,
  input  logic [1:0]   operation,
  input  logic [W-1:0] data_a,
  input  logic [W-1:0] data_b,
  output logic         busy,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic         op_mod_add_subt,
  output logic         start_add_subt,
  output logic         start_mult,
  output logic         start_cordic,
  input  logic         ready_add_subt,
  input  logic         ready_mult,
  input  logic         ready_cordic,
  input  logic [W-1:0] result_add_subt,
  input  logic [W-1:0] result_mult,
  input  logic [W-1:0] result_cordic,
  output logic [W-1:0] final_result,
  output logic         ready_flag,
  output logic         timeout_err
);
  state_t state, next;
  logic [1:0] op_q;
  logic sel_rdy, expire;
  logic [W-1:0] sel_res;
  always_comb begin
    sel_rdy = op_q == OP_MULT ? ready_mult : op_q == OP_CORDIC ? ready_cordic : ready_add_subt;
    sel_res = op_q == OP_MULT ? result_mult : op_q == OP_CORDIC ? result_cordic : result_add_subt;
  end
`ifdef FPU_DISPATCH_TMO_EN
  fpu_op_watchdog #(.TMO_CYC(TMO_CYC)) u_wd (
    .clk(clk),
    .rst(rst),
    .active(state == S_WAIT),
    .expire(expire)
  );
`else
  // no watchdog: WAIT holds until the selected unit answers
  assign expire = TMO_CYC < 0;
`endif
  always_comb begin
    next = state;
    case (state)
      S_IDLE:  next = beg_op ? S_LOAD : S_IDLE;
      S_LOAD:  next = S_ISSUE;
      S_ISSUE: next = S_WAIT;
      S_WAIT:  next = (sel_rdy || expire) ? S_DONE : S_WAIT;
      default: next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state        <= S_IDLE;
      op_q         <= OP_ADD;
      op_a         <= '0;
      op_b         <= '0;
      final_result <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state       <= next;
      timeout_err <= state == S_WAIT && !sel_rdy && expire;
      if (state == S_IDLE && beg_op) begin
        op_q <= operation;
        op_a <= data_a;
        op_b <= data_b;
      end
      if (state == S_WAIT && sel_rdy) final_result <= sel_res;
      else if (state == S_WAIT && expire) final_result <= '0;
    end
  always_comb begin
    busy            = state != S_IDLE;
    op_mod_add_subt = busy && op_q == OP_SUB;
    start_add_subt  = state == S_ISSUE && !op_q[1];
    start_mult      = state == S_ISSUE && op_q == OP_MULT;
    start_cordic    = state == S_ISSUE && op_q == OP_CORDIC;
    ready_flag      = state == S_DONE;
  end
endmodule

// File: tb/tb_fpu_op_dispatch.sv
// tb_fpu_op_dispatch: directed self-checking bench for fpu_op_dispatch; timeout scenario runs when FPU_DISPATCH_TMO_EN is defined.
module tb_fpu_op_dispatch;
`ifdef FPU_DISPATCH_TMO_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif
  logic clk = 1'b0, rst = 1'b0, beg_op = 1'b0;
  logic [1:0] operation = 2'b00;
  logic [31:0] data_a = '0, data_b = '0;
  logic busy, op_mod_add_subt, start_add_subt, start_mult, start_cordic, ready_flag, timeout_err;
  logic [31:0] op_a, op_b, final_result;
  logic ready_add_subt = 1'b0, ready_mult = 1'b0, ready_cordic = 1'b0;
  logic [31:0] result_add_subt = '0, result_mult = '0, result_cordic = '0;
  int n_tests = 0, n_fail = 0;

  fpu_op_dispatch #(.W(32), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .beg_op(beg_op), .operation(operation),
    .data_a(data_a), .data_b(data_b), .busy(busy), .op_a(op_a), .op_b(op_b),
    .op_mod_add_subt(op_mod_add_subt), .start_add_subt(start_add_subt),
    .start_mult(start_mult), .start_cordic(start_cordic),
    .ready_add_subt(ready_add_subt), .ready_mult(ready_mult), .ready_cordic(ready_cordic),
    .result_add_subt(result_add_subt), .result_mult(result_mult), .result_cordic(result_cordic),
    .final_result(final_result), .ready_flag(ready_flag), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_tests++; if ({busy, op_mod_add_subt, start_add_subt, start_mult, start_cordic, ready_flag, timeout_err} !== 7'b0) begin n_fail++; $display("FAIL reset_ctrl got %b exp 0", {busy, op_mod_add_subt, start_add_subt, start_mult, start_cordic, ready_flag, timeout_err}); end
    n_tests++; if (op_a !== 32'h0) begin n_fail++; $display("FAIL reset_op_a got %h exp 0", op_a); end
    n_tests++; if (op_b !== 32'h0) begin n_fail++; $display("FAIL reset_op_b got %h exp 0", op_b); end
    n_tests++; if (final_result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h exp 0", final_result); end
  endtask

  task automatic test_add();
    beg_op = 1'b1; operation = 2'b00; data_a = 32'h3F800000; data_b = 32'h40000000;
    tick();
    beg_op = 1'b0; data_a = 32'hDEADBEEF; data_b = 32'h12345678;
    n_tests++; if ({busy, start_add_subt} !== 2'b10) begin n_fail++; $display("FAIL add_load got %b exp 10", {busy, start_add_subt}); end
    tick();
    n_tests++; if ({start_add_subt, start_mult, start_cordic, op_mod_add_subt} !== 4'b1000) begin n_fail++; $display("FAIL add_issue got %b exp 1000", {start_add_subt, start_mult, start_cordic, op_mod_add_subt}); end
    n_tests++; if ({op_a, op_b} !== {32'h3F800000, 32'h40000000}) begin n_fail++; $display("FAIL add_operands got %h exp 3f80000040000000", {op_a, op_b}); end
    tick();
    n_tests++; if (start_add_subt !== 1'b0) begin n_fail++; $display("FAIL add_start_width got %b exp 0", start_add_subt); end
    tick();
    tick();
    ready_add_subt = 1'b1; result_add_subt = 32'h40400000;
    tick();
    ready_add_subt = 1'b0; result_add_subt = 32'h0;
    n_tests++; if ({busy, ready_flag, final_result} !== {2'b11, 32'h40400000}) begin n_fail++; $display("FAIL add_done got %b %b %h exp 1 1 40400000", busy, ready_flag, final_result); end
    tick();
    n_tests++; if ({busy, ready_flag, final_result} !== {2'b00, 32'h40400000}) begin n_fail++; $display("FAIL add_idle got %b %b %h exp 0 0 40400000", busy, ready_flag, final_result); end
  endtask

  task automatic test_opcodes();
    logic [2:0] exp_st [4] = '{3'b100, 3'b100, 3'b010, 3'b001};
    logic [31:0] exp_res [4] = '{32'hA0, 32'hA1, 32'hB2, 32'hC3};
    for (int i = 0; i < 4; i++) begin
      beg_op = 1'b1; operation = 2'(i); data_a = 32'h1000 + i; data_b = 32'h2000 + i;
      tick();
      beg_op = 1'b0;
      tick();
      n_tests++; if ({start_add_subt, start_mult, start_cordic} !== exp_st[i]) begin n_fail++; $display("FAIL op%0d_start got %b exp %b", i, {start_add_subt, start_mult, start_cordic}, exp_st[i]); end
      n_tests++; if (op_mod_add_subt !== (i == 1)) begin n_fail++; $display("FAIL op%0d_mod got %b exp %b", i, op_mod_add_subt, i == 1); end
      tick();
      {ready_add_subt, ready_mult, ready_cordic} = exp_st[i];
      result_add_subt = 32'hA0 + i; result_mult = 32'hB0 + i; result_cordic = 32'hC0 + i;
      tick();
      {ready_add_subt, ready_mult, ready_cordic} = 3'b000;
      n_tests++; if ({ready_flag, final_result} !== {1'b1, exp_res[i]}) begin n_fail++; $display("FAIL op%0d_result got %b %h exp 1 %h", i, ready_flag, final_result, exp_res[i]); end
      tick();
    end
  endtask

  task automatic test_wrong_ready();
    beg_op = 1'b1; operation = 2'b10; data_a = 32'h3; data_b = 32'h4;
    ready_mult = 1'b1; result_mult = 32'hBAD0;
    tick();
    beg_op = 1'b0;
    tick();
    tick();
    ready_mult = 1'b0;
    ready_cordic = 1'b1; ready_add_subt = 1'b1; result_cordic = 32'hBAD1; result_add_subt = 32'hBAD2;
    tick();
    ready_cordic = 1'b0; ready_add_subt = 1'b0;
    n_tests++; if ({busy, ready_flag} !== 2'b10) begin n_fail++; $display("FAIL wrong_ready_ignored got %b exp 10", {busy, ready_flag}); end
    tick();
    n_tests++; if ({busy, ready_flag} !== 2'b10) begin n_fail++; $display("FAIL wrong_ready_still_wait got %b exp 10", {busy, ready_flag}); end
    ready_mult = 1'b1; result_mult = 32'h55;
    tick();
    ready_mult = 1'b0;
    n_tests++; if ({ready_flag, final_result} !== {1'b1, 32'h55}) begin n_fail++; $display("FAIL wrong_ready_mult got %b %h exp 1 00000055", ready_flag, final_result); end
    tick();
  endtask

  task automatic test_busy_drop();
    int flags = 0;
    beg_op = 1'b1; operation = 2'b00; data_a = 32'h11; data_b = 32'h22;
    tick();
    beg_op = 1'b0;
    tick();
    tick();
    beg_op = 1'b1; operation = 2'b11; data_a = 32'h99; data_b = 32'h98;
    tick();
    beg_op = 1'b0;
    n_tests++; if ({start_cordic, op_a} !== {1'b0, 32'h11}) begin n_fail++; $display("FAIL drop_no_capture got %b %h exp 0 00000011", start_cordic, op_a); end
    ready_add_subt = 1'b1; result_add_subt = 32'h77;
    tick();
    ready_add_subt = 1'b0;
    n_tests++; if ({ready_flag, final_result} !== {1'b1, 32'h77}) begin n_fail++; $display("FAIL drop_done got %b %h exp 1 00000077", ready_flag, final_result); end
    tick();
    flags += int'(ready_flag);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle_busy got %b exp 0", busy); end
    beg_op = 1'b1; operation = 2'b10; data_a = 32'h66; data_b = 32'h67;
    tick();
    beg_op = 1'b0;
    flags += int'(ready_flag);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got %b exp 1", busy); end
    tick();
    flags += int'(ready_flag);
    n_tests++; if ({start_mult, start_cordic, op_a} !== {2'b10, 32'h66}) begin n_fail++; $display("FAIL b2b_start got %b %b %h exp 1 0 00000066", start_mult, start_cordic, op_a); end
    n_tests++; if (flags !== 0) begin n_fail++; $display("FAIL drop_extra_flags got %0d exp 0", flags); end
    tick();
    ready_mult = 1'b1; result_mult = 32'h88;
    tick();
    ready_mult = 1'b0;
    n_tests++; if ({ready_flag, final_result} !== {1'b1, 32'h88}) begin n_fail++; $display("FAIL b2b_done got %b %h exp 1 00000088", ready_flag, final_result); end
    tick();
  endtask

`ifdef FPU_DISPATCH_TMO_EN
  task automatic test_timeout();
    int early = 0;
    beg_op = 1'b1; operation = 2'b00; data_a = 32'h5; data_b = 32'h6;
    tick();
    beg_op = 1'b0;
    tick();
    tick();
    for (int k = 1; k < 8; k++) begin
      tick();
      early += int'(ready_flag | timeout_err);
    end
    n_tests++; if (early !== 0) begin n_fail++; $display("FAIL tmo_early got %0d exp 0", early); end
    tick();
    n_tests++; if ({timeout_err, ready_flag, final_result} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL tmo_expire got %b %b %h exp 1 1 0", timeout_err, ready_flag, final_result); end
    tick();
    n_tests++; if ({timeout_err, busy} !== 2'b00) begin n_fail++; $display("FAIL tmo_after got %b exp 00", {timeout_err, busy}); end
    beg_op = 1'b1;
    tick();
    beg_op = 1'b0;
    tick();
    tick();
    for (int k = 1; k < 8; k++) tick();
    ready_add_subt = 1'b1; result_add_subt = 32'h4242;
    tick();
    ready_add_subt = 1'b0;
    n_tests++; if ({timeout_err, ready_flag, final_result} !== {2'b01, 32'h4242}) begin n_fail++; $display("FAIL tmo_ready_wins got %b %b %h exp 0 1 00004242", timeout_err, ready_flag, final_result); end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    int flags = 0;
    beg_op = 1'b1; operation = 2'b01; data_a = 32'h5; data_b = 32'h6;
    tick();
    beg_op = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 100; k++) begin
      tick();
      flags += int'(ready_flag | timeout_err);
    end
    n_tests++; if ({busy, flags} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL no_tmo_wait got busy %b flags %0d exp 1 0", busy, flags); end
    ready_add_subt = 1'b1; result_add_subt = 32'h31;
    tick();
    ready_add_subt = 1'b0;
    n_tests++; if ({ready_flag, timeout_err, final_result} !== {2'b10, 32'h31}) begin n_fail++; $display("FAIL no_tmo_done got %b %b %h exp 1 0 00000031", ready_flag, timeout_err, final_result); end
    tick();
  endtask
`endif

  task automatic test_abort();
    int pulses = 0;
    beg_op = 1'b1; operation = 2'b10; data_a = 32'hAB; data_b = 32'hCD;
    tick();
    beg_op = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1; ready_mult = 1'b1; result_mult = 32'hEE;
    tick();
    tick();
    rst = 1'b0; ready_mult = 1'b0;
    n_tests++; if ({busy, op_mod_add_subt, start_add_subt, start_mult, start_cordic, ready_flag, timeout_err} !== 7'b0) begin n_fail++; $display("FAIL abort_ctrl got %b exp 0", {busy, op_mod_add_subt, start_add_subt, start_mult, start_cordic, ready_flag, timeout_err}); end
    n_tests++; if ({op_a, op_b, final_result} !== 96'h0) begin n_fail++; $display("FAIL abort_data got %h exp 0", {op_a, op_b, final_result}); end
    for (int k = 0; k < 4; k++) begin
      tick();
      pulses += int'(ready_flag | start_mult | busy);
    end
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_quiet got %0d exp 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_opcodes();
    test_wrong_ready();
    test_busy_drop();
`ifdef FPU_DISPATCH_TMO_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
